// File: rtl/gameboy_pkg.sv
// Shared bus types for the Game Boy core: request encoding, arbiter states and HRAM decode.
package gameboy_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE        = 2'd0,
    BUS_READ        = 2'd1,
    BUS_WRITE       = 2'd2,
    BUS_FINISHED_OP = 2'd3
  } bus_op_t;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_CAPTURE,
    ARB_PAD,
    ARB_DONE
  } arb_state_t;

  localparam logic [15:0] HRAM_START = 16'hFF80;
  localparam logic [15:0] HRAM_END   = 16'hFFFE;

  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_START) && (addr <= HRAM_END);
  endfunction

  function automatic logic is_request(input bus_op_t op);
    return (op == BUS_READ) || (op == BUS_WRITE);
  endfunction

endpackage

// File: rtl/mmu_bus_arbiter_timer.sv
// Access-length timer: loaded while the arbiter is in ISSUE, counts down through PAD.
module bus_access_timer #(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CW = $clog2(ACCESS_CYCLES);

  logic [CW-1:0] count;

  // NOTE: non-blocking assignments for every register so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(ACCESS_CYCLES - 3);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Zero means no PAD cycles remain: CAPTURE or PAD moves straight to DONE.
  assign expired = (count == '0);

endmodule

// File: rtl/mmu_bus_arbiter.sv
// CPU / OAM-DMA arbiter for the single MMU port; fixed-length accesses, DMA has priority.
// Optional build macro: BUS_ARB_DMA_LOCKOUT_EN (blocks non-HRAM CPU accesses during OAM DMA).
module mmu_bus_arbiter
  import gameboy_pkg::*;
#(
  parameter int ACCESS_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  bus_op_t     cpu_bus_op,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_done,
  input  bus_op_t     dma_bus_op,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_done,
  input  logic        dma_active,
  output logic        grant_dma,
  output logic [15:0] mmu_address,
  output logic [7:0]  mmu_write_data,
  output logic        mmu_read_en,
  output logic        mmu_write_en,
  input  logic [7:0]  mmu_read_data
);

  arb_state_t state;
  logic       read_q;
  logic       blocked_q;
  logic       dma_req;
  logic       cpu_req;
  logic       cpu_blocked;
  logic       timer_load;
  logic       timer_dec;
  logic       pad_expired;
  logic       enter_done;

  assign dma_req = is_request(dma_bus_op);
  assign cpu_req = is_request(cpu_bus_op);

`ifdef BUS_ARB_DMA_LOCKOUT_EN
  assign cpu_blocked = dma_active && !is_hram(cpu_addr);
`else
  logic unused_dma_active;
  assign unused_dma_active = dma_active;
  assign cpu_blocked       = 1'b0;
`endif

  assign timer_load = (state == ARB_ISSUE);
  assign timer_dec  = (state == ARB_CAPTURE) || (state == ARB_PAD);
  assign enter_done = timer_dec && pad_expired;

  bus_access_timer #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .dec     (timer_dec),
    .expired (pad_expired)
  );

  // mmu_address/mmu_write_data double as the request latch: loaded once when leaving
  // IDLE and held until the next issued transfer, so input changes never reach the MMU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ARB_IDLE;
      read_q         <= 1'b0;
      blocked_q      <= 1'b0;
      grant_dma      <= 1'b0;
      mmu_address    <= '0;
      mmu_write_data <= '0;
      mmu_read_en    <= 1'b0;
      mmu_write_en   <= 1'b0;
      cpu_done       <= 1'b0;
      dma_done       <= 1'b0;
      cpu_rdata      <= 8'hFF;
      dma_rdata      <= 8'hFF;
    end else begin
      mmu_read_en  <= 1'b0;
      mmu_write_en <= 1'b0;
      cpu_done     <= 1'b0;
      dma_done     <= 1'b0;

      case (state)
        ARB_IDLE: begin
          if (dma_req) begin
            state          <= ARB_ISSUE;
            grant_dma      <= 1'b1;
            read_q         <= (dma_bus_op == BUS_READ);
            blocked_q      <= 1'b0;
            mmu_address    <= dma_addr;
            mmu_write_data <= dma_wdata;
            mmu_read_en    <= (dma_bus_op == BUS_READ);
            mmu_write_en   <= (dma_bus_op == BUS_WRITE);
          end else if (cpu_req) begin
            state     <= ARB_ISSUE;
            grant_dma <= 1'b0;
            read_q    <= (cpu_bus_op == BUS_READ);
            blocked_q <= cpu_blocked;
            if (!cpu_blocked) begin
              mmu_address    <= cpu_addr;
              mmu_write_data <= cpu_wdata;
              mmu_read_en    <= (cpu_bus_op == BUS_READ);
              mmu_write_en   <= (cpu_bus_op == BUS_WRITE);
            end
          end
        end
        ARB_ISSUE: state <= ARB_CAPTURE;
        ARB_CAPTURE: begin
          state <= ARB_PAD;
          if (read_q) begin
            if (blocked_q)      cpu_rdata <= 8'hFF;
            else if (grant_dma) dma_rdata <= mmu_read_data;
            else                cpu_rdata <= mmu_read_data;
          end
        end
        ARB_PAD:  state <= ARB_PAD;
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase

      // Overrides the CAPTURE/PAD next-state above once the access length is used up.
      if (enter_done) begin
        state    <= ARB_DONE;
        dma_done <= grant_dma;
        cpu_done <= !grant_dma;
      end
    end
  end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Scoreboard bench for mmu_bus_arbiter: stimulus queues expected MMU issues and done pulses,
// an independent monitor pops and compares them as the DUT produces them.
module tb_mmu_bus_arbiter;
  import gameboy_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  bus_op_t     cpu_bus_op = BUS_IDLE;
  logic [15:0] cpu_addr   = '0;
  logic [7:0]  cpu_wdata  = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  bus_op_t     dma_bus_op = BUS_IDLE;
  logic [15:0] dma_addr   = '0;
  logic [7:0]  dma_wdata  = '0;
  logic [7:0]  dma_rdata;
  logic        dma_done;
  logic        dma_active = 1'b0;
  logic        grant_dma;
  logic [15:0] mmu_address;
  logic [7:0]  mmu_write_data;
  logic        mmu_read_en;
  logic        mmu_write_en;
  logic [7:0]  mmu_read_data = '0;

  mmu_bus_arbiter #(.ACCESS_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_bus_op     (cpu_bus_op),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_done       (cpu_done),
    .dma_bus_op     (dma_bus_op),
    .dma_addr       (dma_addr),
    .dma_wdata      (dma_wdata),
    .dma_rdata      (dma_rdata),
    .dma_done       (dma_done),
    .dma_active     (dma_active),
    .grant_dma      (grant_dma),
    .mmu_address    (mmu_address),
    .mmu_write_data (mmu_write_data),
    .mmu_read_en    (mmu_read_en),
    .mmu_write_en   (mmu_write_en),
    .mmu_read_data  (mmu_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MMU model: fixed contents, registered read data one cycle after read_en.
  function automatic logic [7:0] mem(input logic [15:0] a);
    case (a)
      16'hC000: return 8'h5A;
      16'h8000: return 8'hA5;
      16'hFF90: return 8'h77;
      default:  return a[7:0] ^ 8'h33;
    endcase
  endfunction

  always @(posedge clk) if (mmu_read_en) mmu_read_data <= mem(mmu_address);

  typedef struct {
    int          cyc;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } issue_t;

  typedef struct {
    int          cyc;
    logic        dma;
    logic [7:0]  rdata;
  } done_t;

  issue_t issue_q[$];
  done_t  done_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_issue(input int c, input logic re, input logic [15:0] a, input logic [7:0] wd);
    issue_t e;
    e.cyc = c; e.re = re; e.we = !re; e.addr = a; e.wdata = wd;
    issue_q.push_back(e);
  endtask

  task automatic exp_done(input int c, input logic is_dma, input logic [7:0] rd);
    done_t e;
    e.cyc = c; e.dma = is_dma; e.rdata = rd;
    done_q.push_back(e);
  endtask

  // One request from one requester, held until its done cycle, then withdrawn.
  task automatic xfer(input logic is_dma, input bus_op_t op, input logic [15:0] a,
                      input logic [7:0] wd, input logic issued, input logic [7:0] rd);
    int t;
    t = cyc;
    if (is_dma) begin dma_bus_op = op; dma_addr = a; dma_wdata = wd; end
    else        begin cpu_bus_op = op; cpu_addr = a; cpu_wdata = wd; end
    if (issued) exp_issue(t + 1, op == BUS_READ, a, wd);
    exp_done(t + 4, is_dma, rd);
    repeat (4) @(negedge clk);
    if (is_dma) dma_bus_op = BUS_IDLE;
    else        cpu_bus_op = BUS_FINISHED_OP;
    @(negedge clk);
  endtask

  // Monitor: compares every MMU issue and done pulse against the head of its queue.
  initial begin
    issue_t ei;
    done_t  ed;
    forever begin
      @(negedge clk);
      #1;
      if (mmu_read_en || mmu_write_en) begin
        if (issue_q.size() == 0) begin
          check("unexpected_issue", {30'd0, mmu_read_en, mmu_write_en}, 32'd0);
        end else begin
          ei = issue_q.pop_front();
          check("issue_cycle", cyc, ei.cyc);
          check("issue_read_en", mmu_read_en, ei.re);
          check("issue_write_en", mmu_write_en, ei.we);
          check("issue_addr", mmu_address, ei.addr);
          if (ei.we) check("issue_wdata", mmu_write_data, ei.wdata);
        end
      end
      if (cpu_done || dma_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", {30'd0, dma_done, cpu_done}, 32'd0);
        end else begin
          ed = done_q.pop_front();
          check("done_cycle", cyc, ed.cyc);
          check("done_who", {dma_done, cpu_done}, ed.dma ? 2'b10 : 2'b01);
          check("done_grant", grant_dma, ed.dma);
          check("done_rdata", ed.dma ? dma_rdata : cpu_rdata, ed.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_read_en", mmu_read_en, 1'b0);
    check("rst_write_en", mmu_write_en, 1'b0);
    check("rst_address", mmu_address, 16'h0000);
    check("rst_wdata", mmu_write_data, 8'h00);
    check("rst_cpu_done", cpu_done, 1'b0);
    check("rst_dma_done", dma_done, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 8'hFF);
    check("rst_dma_rdata", dma_rdata, 8'hFF);
    check("rst_grant", grant_dma, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic CPU read, then write leaving cpu_rdata untouched.
    xfer(1'b0, BUS_READ,  16'hC000, 8'h00, 1'b1, 8'h5A);
    xfer(1'b0, BUS_WRITE, 16'hC001, 8'h3C, 1'b1, 8'h5A);

    // Simultaneous arrival: DMA first, CPU issued five cycles later.
    t = cyc;
    cpu_bus_op = BUS_WRITE; cpu_addr = 16'hC001; cpu_wdata = 8'h3C;
    dma_bus_op = BUS_READ;  dma_addr = 16'h8000; dma_wdata = 8'h00;
    exp_issue(t + 1, 1'b1, 16'h8000, 8'h00);
    exp_done(t + 4, 1'b1, 8'hA5);
    exp_issue(t + 6, 1'b0, 16'hC001, 8'h3C);
    exp_done(t + 9, 1'b0, 8'h5A);
    repeat (4) @(negedge clk);
    dma_bus_op = BUS_IDLE;
    repeat (5) @(negedge clk);
    cpu_bus_op = BUS_FINISHED_OP;
    @(negedge clk);

    // DMA write keeps dma_rdata.
    xfer(1'b1, BUS_WRITE, 16'h8001, 8'h55, 1'b1, 8'hA5);

    // CPU accesses while OAM DMA is running; HRAM edges FF80 (inside) and FFFF (outside).
    dma_active = 1'b1;
`ifdef BUS_ARB_DMA_LOCKOUT_EN
    xfer(1'b0, BUS_READ, 16'h4000, 8'h00, 1'b0, 8'hFF);
    xfer(1'b0, BUS_READ, 16'hFFFF, 8'h00, 1'b0, 8'hFF);
`else
    xfer(1'b0, BUS_READ, 16'h4000, 8'h00, 1'b1, 8'h33);
    xfer(1'b0, BUS_READ, 16'hFFFF, 8'h00, 1'b1, 8'hCC);
`endif
    xfer(1'b0, BUS_READ, 16'hFF90, 8'h00, 1'b1, 8'h77);
    xfer(1'b0, BUS_READ, 16'hFF80, 8'h00, 1'b1, 8'hB3);
    dma_active = 1'b0;

    // Reset asserted during CAPTURE: abandoned, no done.
    t = cyc;
    cpu_bus_op = BUS_READ; cpu_addr = 16'h1111;
    exp_issue(t + 1, 1'b1, 16'h1111, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cpu_bus_op = BUS_IDLE;
    #1;
    check("abort_read_en", mmu_read_en, 1'b0);
    check("abort_cpu_rdata", cpu_rdata, 8'hFF);
    check("abort_cpu_done", cpu_done, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_no_done", cpu_done, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    xfer(1'b0, BUS_READ, 16'h1234, 8'h00, 1'b1, 8'h07);

    // CPU op held across three transfers: issue every five cycles, then FINISHED_OP idles.
    t = cyc;
    cpu_bus_op = BUS_READ; cpu_addr = 16'hC000;
    for (int k = 0; k < 3; k++) begin
      exp_issue(t + 1 + 5 * k, 1'b1, 16'hC000, 8'h00);
      exp_done(t + 4 + 5 * k, 1'b0, 8'h5A);
    end
    repeat (14) @(negedge clk);
    cpu_bus_op = BUS_FINISHED_OP;
    repeat (10) @(negedge clk);
    cpu_bus_op = BUS_IDLE;
    repeat (3) @(negedge clk);

    check("issue_queue_drained", issue_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
